// File: rtl/rs232_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs232_cmd_parser_pkg
// Description : Shared definitions for the RS-232 ASCII command parser.
//               Holds the ASCII constants, error code values, the FSM state
//               and field-phase encodings, and the clogb2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rs232_cmd_parser_pkg;

    localparam logic [7:0] c_ASCII_CR = 8'h0D;
    localparam logic [7:0] c_ASCII_LF = 8'h0A;
    localparam logic [7:0] c_ASCII_W  = 8'h57;
    localparam logic [7:0] c_ASCII_R  = 8'h52;

    // Clearing bit 5 folds lower-case letters onto upper-case.
    localparam logic [7:0] c_CASE_MASK = 8'hDF;

    localparam logic [1:0] c_ERR_NONE     = 2'd0;
    localparam logic [1:0] c_ERR_BAD_CHAR = 2'd1;
    localparam logic [1:0] c_ERR_BAD_LEN  = 2'd2;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_POP     = 3'd1,
        S_PARSE   = 3'd2,
        S_EXEC    = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_CMD  = 2'd0,
        PH_ADDR = 2'd1,
        PH_DATA = 2'd2,
        PH_EOL  = 2'd3
    } phase_t;

    // Number of bits needed to hold the values 0 .. value-1 (minimum 1).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_cmd_parser_hex_ascii_decode.sv
`default_nettype none
// ============================================================================
// Module      : rs232_cmd_parser_hex_ascii_decode
// Description : Combinational ASCII hex digit decoder.
//               i_byte   - ASCII character
//               o_is_hex - character is 0-9, A-F or a-f
//               o_nibble - value of the digit (0 when not hex)
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_cmd_parser_hex_ascii_decode (
    input  logic [7:0] i_byte,
    output logic       o_is_hex,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_is_hex = 1'b0;
        o_nibble = 4'h0;
        if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            o_is_hex = 1'b1;
            o_nibble = i_byte[3:0];
        end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                     (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 yields 10.
            o_is_hex = 1'b1;
            o_nibble = i_byte[3:0] + 4'd9;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rs232_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : rs232_cmd_parser
// Description : Pops ASCII characters from the RS-232 receive FIFO, assembles
//               W<addr><data>CR / R<addr>CR hex commands and issues one
//               register-bus transaction per valid line.
// Ports       : clk, rst (async, active-high)
//               rx_fifo_empty / rx_fifo_rd_en / rx_fifo_data - FIFO read side
//               reg_addr, reg_wdata, reg_wr, reg_rd, reg_ack - register bus
//               err, err_code - error strobe (1 bad char, 2 bad length,
//                               3 ack timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_cmd_parser
    import rs232_cmd_parser_pkg::*;
#(
    parameter int P_ADDR_NIB    = 4,
    parameter int P_DATA_NIB    = 4,
    parameter int P_ACK_TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_fifo_empty,
    output logic                    rx_fifo_rd_en,
    input  logic [7:0]              rx_fifo_data,
    output logic [4*P_ADDR_NIB-1:0] reg_addr,
    output logic [4*P_DATA_NIB-1:0] reg_wdata,
    output logic                    reg_wr,
    output logic                    reg_rd,
    input  logic                    reg_ack,
    output logic                    err,
    output logic [1:0]              err_code
);

    localparam int c_AW      = 4 * P_ADDR_NIB;
    localparam int c_DW      = 4 * P_DATA_NIB;
    localparam int c_TW      = clogb2(P_ACK_TIMEOUT + 1);
    localparam int c_MAX_NIB = (P_ADDR_NIB > P_DATA_NIB) ? P_ADDR_NIB : P_DATA_NIB;
    localparam int c_NW      = clogb2(c_MAX_NIB + 1);

    state_t            r_state;
    phase_t            r_phase;
    logic [c_NW-1:0]   r_nib;
    logic              r_is_wr;
    logic              r_dropping;
    logic [c_AW-1:0]   r_addr_sh;
    logic [c_DW-1:0]   r_data_sh;
    logic [c_TW-1:0]   r_timer;
    logic              r_rd_en;
    logic [c_AW-1:0]   r_reg_addr;
    logic [c_DW-1:0]   r_reg_wdata;
    logic              r_reg_wr;
    logic              r_reg_rd;
    logic              r_err;
    logic [1:0]        r_err_code;

    logic              w_is_hex;
    logic [3:0]        w_nib;
    logic              w_is_cr;
    logic              w_is_lf;
    logic              w_is_w;
    logic              w_is_r;
    logic              w_last_addr;
    logic              w_last_data;

    rs232_cmd_parser_hex_ascii_decode u_hex_dec (
        .i_byte   (rx_fifo_data),
        .o_is_hex (w_is_hex),
        .o_nibble (w_nib)
    );

    assign w_is_cr     = (rx_fifo_data == c_ASCII_CR);
    assign w_is_lf     = (rx_fifo_data == c_ASCII_LF);
    assign w_is_w      = ((rx_fifo_data & c_CASE_MASK) == c_ASCII_W);
    assign w_is_r      = ((rx_fifo_data & c_CASE_MASK) == c_ASCII_R);
    assign w_last_addr = (r_nib == c_NW'(P_ADDR_NIB - 1));
    assign w_last_data = (r_nib == c_NW'(P_DATA_NIB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= PH_CMD;
            r_nib       <= '0;
            r_is_wr     <= 1'b0;
            r_dropping  <= 1'b0;
            r_addr_sh   <= '0;
            r_data_sh   <= '0;
            r_timer     <= '0;
            r_rd_en     <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= c_ERR_NONE;
        end else begin
            r_rd_en <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                // S_DISCARD waits for bytes exactly like S_IDLE; r_dropping
                // tells S_PARSE to throw the byte away.
                S_IDLE, S_DISCARD: begin
                    if (!rx_fifo_empty) begin
                        r_rd_en <= 1'b1;
                        r_state <= S_POP;
                    end
                end
                S_POP: r_state <= S_PARSE;
                S_PARSE: begin
                    r_state <= S_IDLE;
                    if (r_dropping) begin
                        if (w_is_cr) r_dropping <= 1'b0;
                        else         r_state    <= S_DISCARD;
                    end else if (w_is_lf) begin
                        r_phase <= r_phase;
                    end else if (w_is_cr) begin
                        if (r_phase == PH_EOL) begin
                            r_reg_addr  <= r_addr_sh;
                            r_reg_wdata <= r_data_sh;
                            r_timer     <= '0;
                            r_phase     <= PH_CMD;
                            r_state     <= S_EXEC;
                        end else if (r_phase != PH_CMD) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_ERR_BAD_LEN;
                            r_phase    <= PH_CMD;
                        end
                    end else begin
                        case (r_phase)
                            PH_CMD: begin
                                if (w_is_w || w_is_r) begin
                                    r_is_wr   <= w_is_w;
                                    r_phase   <= PH_ADDR;
                                    r_nib     <= '0;
                                    r_addr_sh <= '0;
                                    r_data_sh <= '0;
                                end else begin
                                    r_err      <= 1'b1;
                                    r_err_code <= c_ERR_BAD_CHAR;
                                    r_dropping <= 1'b1;
                                    r_state    <= S_DISCARD;
                                end
                            end
                            PH_ADDR, PH_DATA: begin
                                if (w_is_hex) begin
                                    r_nib <= r_nib + c_NW'(1);
                                    if (r_phase == PH_ADDR) begin
                                        r_addr_sh <= (r_addr_sh << 4) | c_AW'(w_nib);
                                        if (w_last_addr) begin
                                            r_nib   <= '0;
                                            r_phase <= r_is_wr ? PH_DATA : PH_EOL;
                                        end
                                    end else begin
                                        r_data_sh <= (r_data_sh << 4) | c_DW'(w_nib);
                                        if (w_last_data) begin
                                            r_nib   <= '0;
                                            r_phase <= PH_EOL;
                                        end
                                    end
                                end else begin
                                    r_err      <= 1'b1;
                                    r_err_code <= c_ERR_BAD_CHAR;
                                    r_phase    <= PH_CMD;
                                    r_dropping <= 1'b1;
                                    r_state    <= S_DISCARD;
                                end
                            end
                            PH_EOL: begin
                                // A hex digit here means the line is too long.
                                r_err      <= 1'b1;
                                r_err_code <= w_is_hex ? c_ERR_BAD_LEN : c_ERR_BAD_CHAR;
                                r_phase    <= PH_CMD;
                                r_dropping <= 1'b1;
                                r_state    <= S_DISCARD;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    // First EXEC cycle raises the request; acks are only
                    // meaningful once it is visible on the bus.
                    if (!(r_reg_wr || r_reg_rd)) begin
                        r_reg_wr <= r_is_wr;
                        r_reg_rd <= !r_is_wr;
                        r_timer  <= '0;
                    end else if (reg_ack) begin
                        r_reg_wr <= 1'b0;
                        r_reg_rd <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (r_timer == c_TW'(P_ACK_TIMEOUT - 1)) begin
                        r_reg_wr   <= 1'b0;
                        r_reg_rd   <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_TIMEOUT;
                        r_state    <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_fifo_rd_en = r_rd_en;
    assign reg_addr      = r_reg_addr;
    assign reg_wdata     = r_reg_wdata;
    assign reg_wr        = r_reg_wr;
    assign reg_rd        = r_reg_rd;
    assign err           = r_err;
    assign err_code      = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_rs232_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs232_cmd_parser
// Description : Self-checking bench for rs232_cmd_parser. A FIFO model feeds
//               ASCII lines; a line-level reference model predicts the
//               transaction or error each line produces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_cmd_parser;

    localparam int c_AN = 4;
    localparam int c_DN = 4;
    localparam int c_TO = 12;
    localparam int c_AW = 4 * c_AN;
    localparam int c_DW = 4 * c_DN;

    logic            clk = 1'b0;
    logic            rst;
    logic            rx_fifo_empty;
    logic            rx_fifo_rd_en;
    logic [7:0]      rx_fifo_data;
    logic [c_AW-1:0] reg_addr;
    logic [c_DW-1:0] reg_wdata;
    logic            reg_wr;
    logic            reg_rd;
    logic            reg_ack;
    logic            err;
    logic [1:0]      err_code;

    always #5 clk = ~clk;

    rs232_cmd_parser #(
        .P_ADDR_NIB    (c_AN),
        .P_DATA_NIB    (c_DN),
        .P_ACK_TIMEOUT (c_TO)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_rd_en (rx_fifo_rd_en),
        .rx_fifo_data  (rx_fifo_data),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_wr        (reg_wr),
        .reg_rd        (reg_rd),
        .reg_ack       (reg_ack),
        .err           (err),
        .err_code      (err_code)
    );

    typedef struct {
        bit              is_err;
        logic [1:0]      code;
        bit              wr;
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] data;
        int              ack_at;   // 0 = never ack
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_rd_cyc = -100;
    int         hi       = 0;
    int         cur_plan = 0;
    bit         prev_req = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic int hex_val(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 65 + 10;
        return int'(c) - 97 + 10;
    endfunction

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e = '{is_err: 1'b1, code: code, wr: 1'b0, addr: '0, data: '0, ack_at: 0};
        exp_q.push_back(e);
    endtask

    // Queue the line plus CR into the FIFO and predict its outcome.
    task automatic send_line(input logic [7:0] ln[$], input int plan);
        logic [7:0]      s[$];
        logic [c_AW-1:0] a;
        logic [c_DW-1:0] d;
        bit              isw;
        bit              isr;
        int              len;
        exp_t            e;
        foreach (ln[i]) fifo_q.push_back(ln[i]);
        fifo_q.push_back(8'h0D);
        foreach (ln[i]) if (ln[i] != 8'h0A) s.push_back(ln[i]);
        if (s.size() == 0) return;
        isw = (s[0] == "W") || (s[0] == "w");
        isr = (s[0] == "R") || (s[0] == "r");
        if (!isw && !isr) begin push_err(2'd1); return; end
        len = 1 + c_AN + (isw ? c_DN : 0);
        a = '0;
        d = '0;
        for (int i = 1; i < s.size(); i++) begin
            if (i < len) begin
                if (!is_hex(s[i])) begin push_err(2'd1); return; end
                if (i <= c_AN) a = a * 16 + c_AW'(hex_val(s[i]));
                else           d = d * 16 + c_DW'(hex_val(s[i]));
            end else begin
                push_err(is_hex(s[i]) ? 2'd2 : 2'd1);
                return;
            end
        end
        if (s.size() < len) begin push_err(2'd2); return; end
        e = '{is_err: 1'b0, code: 2'd0, wr: isw, addr: a, data: d, ack_at: plan};
        exp_q.push_back(e);
        if (plan == 0) push_err(2'd3);
    endtask

    task automatic push_line(input string str, input int plan);
        logic [7:0] ln[$];
        for (int i = 0; i < str.len(); i++) ln.push_back(str[i]);
        send_line(ln, plan);
    endtask

    function automatic logic [7:0] rand_hex_char();
        int v;
        v = $urandom_range(0, 15);
        if (v < 10) return 8'(48 + v);
        return ($urandom_range(0, 1) == 1) ? 8'(65 + v - 10) : 8'(97 + v - 10);
    endfunction

    task automatic rand_line();
        logic [7:0] ln[$];
        logic [7:0] bad[4];
        int         body;
        int         plan;
        bad[0] = "G"; bad[1] = "z"; bad[2] = " "; bad[3] = "-";
        if ($urandom_range(0, 19) == 0) begin send_line(ln, 1); return; end
        case ($urandom_range(0, 9))
            0:       ln.push_back(rand_hex_char());
            1, 2, 3: ln.push_back("W");
            4, 5:    ln.push_back("w");
            6, 7:    ln.push_back("R");
            default: ln.push_back("r");
        endcase
        body = c_AN + (((ln[0] == "W") || (ln[0] == "w")) ? c_DN : 0);
        if ($urandom_range(0, 3) == 0) body = body + $urandom_range(0, 4) - 2;
        for (int i = 0; i < body; i++) begin
            if ($urandom_range(0, 24) == 0) ln.push_back(bad[$urandom_range(0, 3)]);
            else                            ln.push_back(rand_hex_char());
            if ($urandom_range(0, 11) == 0) ln.push_back(8'h0A);
        end
        case ($urandom_range(0, 7))
            0:       plan = 0;
            1:       plan = c_TO;
            default: plan = $urandom_range(1, 6);
        endcase
        send_line(ln, plan);
    endtask

    // One clock: sample outputs at the falling edge, then update FIFO / ack.
    task automatic step();
        bit   req;
        exp_t e;
        @(negedge clk);
        cyc++;
        req = reg_wr | reg_rd;
        if (rx_fifo_rd_en) begin
            check_eq("pop_while_req", 32'(req), 32'd0);
            check_eq("pop_nonempty", 32'(fifo_q.size() > 0), 32'd1);
            last_rd_cyc = cyc;
            if (fifo_q.size() > 0) rx_fifo_data = fifo_q.pop_front();
        end
        rx_fifo_empty = (fifo_q.size() == 0);
        if (req && !prev_req) begin
            hi = 0;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_req", 32'(req), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("req_not_err", 32'(e.is_err), 32'd0);
                check_eq("req_wr", 32'(reg_wr), 32'(e.wr));
                check_eq("req_rd", 32'(reg_rd), 32'(!e.wr));
                check_eq("req_addr", 32'(reg_addr), 32'(e.addr));
                if (e.wr) check_eq("req_wdata", 32'(reg_wdata), 32'(e.data));
                check_eq("cr_to_req_latency", 32'(cyc - last_rd_cyc), 32'd3);
                cur_plan = e.ack_at;
            end
        end
        if (req) hi++;
        if (!req && prev_req)
            check_eq("req_high_cycles", 32'(hi), 32'((cur_plan == 0) ? c_TO : cur_plan));
        if (err) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_err", 32'(err), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("err_expected", 32'(e.is_err), 32'd1);
                check_eq("err_code", 32'(err_code), 32'(e.code));
            end
        end
        if (req)
            reg_ack = (hi == cur_plan);
        else
            reg_ack = (cyc != last_rd_cyc + 2) && ($urandom_range(0, 9) == 0);
        prev_req = req;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0 || prev_req) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_in_budget", 32'(n < budget), 32'd1);
        repeat (8) step();
    endtask

    initial begin
        rst           = 1'b1;
        rx_fifo_empty = 1'b1;
        rx_fifo_data  = 8'h00;
        reg_ack       = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_rd_en", 32'(rx_fifo_rd_en), 32'd0);
        check_eq("rst_reg_wr", 32'(reg_wr), 32'd0);
        check_eq("rst_reg_rd", 32'(reg_rd), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_err_code", 32'(err_code), 32'd0);
        check_eq("rst_reg_addr", 32'(reg_addr), 32'd0);
        check_eq("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        rst = 1'b0;

        // Directed lines
        push_line("W12AB00FF", 5);
        push_line("r0010", 2);
        fifo_q.push_back(8'h0A);
        push_line("W12G4", 1);
        push_line("R0001", 1);
        push_line("R12", 1);
        push_line("R123456", 1);
        push_line("R0005", 0);
        push_line("", 1);
        push_line("\n", 1);
        push_line("W0000FFFF", c_TO);
        push_line("w\nbeEf1234", 3);
        push_line("Q", 1);
        push_line("R", 1);
        drain(3000);

        // Randomized lines
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 20; i++) rand_line();
            drain(20000);
        end

        // Asynchronous reset while a write request is held
        push_line("W12AB00FF", 0);
        for (int i = 0; i < 200 && !reg_wr; i++) step();
        check_eq("reset_test_req_seen", 32'(reg_wr), 32'd1);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        check_eq("arst_reg_wr", 32'(reg_wr), 32'd0);
        check_eq("arst_rd_en", 32'(rx_fifo_rd_en), 32'd0);
        check_eq("arst_err", 32'(err), 32'd0);
        check_eq("arst_reg_addr", 32'(reg_addr), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        rx_fifo_empty = 1'b1;
        reg_ack       = 1'b0;
        prev_req      = 1'b0;
        push_line("R0001", 3);
        drain(2000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs232_cmd_parser.md
# rs232_cmd_parser

ASCII command parser sitting directly downstream of the RS-232 receive FIFO that the deserializer fills. It pops characters from the FIFO read port and assembles fixed-length hex commands terminated by CR. Each valid command becomes one register-bus transaction toward the firmware register file. Malformed lines and unacknowledged transactions are reported on an error strobe.

## Interface
- P_ADDR_NIB, 4, hex nibbles in the address field (address width = 4*P_ADDR_NIB)
- P_DATA_NIB, 4, hex nibbles in the write-data field (data width = 4*P_DATA_NIB)
- P_ACK_TIMEOUT, 1023, clocks to wait for reg_ack before abandoning a transaction
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset asynchronous active-high
- rx_fifo_empty  in  1  receive FIFO empty
- rx_fifo_rd_en  out  1  one-cycle pop strobe; reset 0
- rx_fifo_data  in  8  FIFO output byte, valid the cycle after rx_fifo_rd_en
- reg_addr  out  4*P_ADDR_NIB  transaction address; reset 0
- reg_wdata  out  4*P_DATA_NIB  write data; reset 0
- reg_wr  out  1  write request, held until ack/timeout; reset 0
- reg_rd  out  1  read request, held until ack/timeout; reset 0
- reg_ack  in  1  register file completion, single-cycle
- err  out  1  one-cycle error pulse; reset 0
- err_code  out  2  1=bad char, 2=bad length, 3=ack timeout; valid with err, holds last value; reset 0

## Operation
- Grammar: W<addr><data>CR or R<addr>CR; command letter case-insensitive; hex digits 0-9, A-F, a-f; fields big-endian (first nibble = MS nibble).
- LF (0x0A) ignored at any position. CR on an empty line is ignored (no error).
- States: S_IDLE, S_POP, S_PARSE, S_EXEC, S_DISCARD.
- S_IDLE: rx_fifo_empty=0 -> assert rx_fifo_rd_en, go S_POP.
- S_POP: wait one cycle (FIFO read latency) -> S_PARSE.
- S_PARSE: classify rx_fifo_data by field phase (CMD, ADDR, DATA, EOL) and nibble count:
  - expected char: shift nibble into reg_addr/reg_wdata shadow, advance phase at field end, return S_IDLE.
  - CR with all fields complete -> S_EXEC.
  - CR early -> err, err_code=2, S_IDLE, parser reset to CMD.
  - hex digit in EOL phase (line too long) -> err, code 2, S_DISCARD.
  - any other unexpected char -> err, code 1, S_DISCARD.
- S_DISCARD: pop and drop bytes until CR, then S_IDLE at CMD phase; no further err pulses for that line.
- S_EXEC: reg_addr/reg_wdata stable; assert reg_wr or reg_rd; on reg_ack deassert next edge, S_IDLE. After P_ACK_TIMEOUT clocks without ack: deassert, err, code 3, S_IDLE.
- reg_ack outside S_EXEC is ignored.
- No FIFO pop while in S_EXEC (backpressure via FIFO).
- Shadow registers are cleared at the start of each new line.

## Timing
- Pop cadence: at most one byte per 3 clocks (IDLE->POP->PARSE).
- CR consumed -> reg_wr/reg_rd high 3 clocks after the CR's rd_en.
- reg_ack sampled high in cycle N -> request low in N+1; next rd_en no earlier than N+1.
- Ack arriving in the same cycle the timeout expires counts as ack (no error).
- err is high exactly one cycle, coincident with err_code update.
- Async rst mid-transaction: all outputs to reset values immediately, state S_IDLE, phase CMD; partial line is lost.
- Timeout counter width = clogb2(P_ACK_TIMEOUT+1).

## Structure
- Shared package/include: ASCII constants (CR, LF, 'W', 'R'), err_code values, clogb2 function (already in fncs.vh).
- One natural sub-module: hex_ascii_decode (combinational byte -> {is_hex, nibble}), reusable by the transmit-side formatter.

## Test plan
- "W12AB00FF\r" -> reg_wr=1, reg_addr=0x12AB, reg_wdata=0x00FF; ack after 5 clks -> reg_wr low next cycle, no err.
- "r0010\r\n" -> reg_rd=1, reg_addr=0x0010; LF ignored; no err.
- "W12G4\r" then "R0001\r" -> err code 1 at 'G', rest dropped; then reg_rd with addr 0x0001.
- "R12\r" -> err code 2, no request; "R123456\r" -> err code 2 once, no request.
- "R0005\r" with reg_ack never asserted -> reg_rd high exactly P_ACK_TIMEOUT clocks, then err code 3.
- rst pulse while reg_wr high -> reg_wr, rx_fifo_rd_en, err low asynchronously; next full command executes normally.
